// File: rtl/ftdi_cmd_pkg.sv
// Shared types and constants for the FTDI byte-stream command decoder.
package ftdi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        ADDR  = 3'd2,
        WDATA = 3'd3,
        WRITE = 3'd4,
        READ  = 3'd5,
        RDATA = 3'd6
    } state_t;

    localparam logic [7:0] CMD_WRITE       = 8'h10;
    localparam logic [7:0] CMD_READ        = 8'h11;
    localparam int         FRAME_HDR_BYTES = 6;

endpackage

// File: rtl/ftdi_cmd_decoder.sv
// Parses CMD/LEN/ADDR[/DATA] byte frames into 32-bit bus reads and writes; read data returns LSB first.
// Optional inter-byte timeout in LEN/ADDR/WDATA is enabled by defining FTDI_CMD_TIMEOUT_EN.
module ftdi_cmd_decoder
    import ftdi_cmd_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport_valid_i,
    input  logic [7:0]  inport_data_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [7:0]  outport_data_o,
    input  logic        outport_accept_i,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    if (TIMEOUT_W < 2) begin : g_timeout_w_check
        $error("TIMEOUT_W must be at least 2");
    end

    state_t      state_q, state_d;
    logic        cmd_wr_q;
    logic [7:0]  len_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        req_q;
    logic        accept_q;
    logic        rx_fire, tx_fire, bus_done, last_word, is_cmd, tmo_hit;

    assign rx_fire   = inport_valid_i & accept_q;
    assign tx_fire   = outport_valid_o & outport_accept_i;
    assign bus_done  = req_q & mem_ack_i;
    assign last_word = (len_q == 8'd1);
    assign is_cmd    = (inport_data_i == CMD_WRITE) || (inport_data_i == CMD_READ);

`ifdef FTDI_CMD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 in_frame;

    assign in_frame = (state_q == LEN) || (state_q == ADDR) || (state_q == WDATA);
    assign tmo_hit  = in_frame && !rx_fire && (tmo_q == {TIMEOUT_W{1'b1}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_q <= '0;
        else if (in_frame && !rx_fire)
            tmo_q <= tmo_q + 1'b1;
        else
            tmo_q <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rx_fire && is_cmd) state_d = LEN;
            LEN:   if (rx_fire) state_d = ADDR;
            ADDR: begin
                if (rx_fire && byte_cnt_q == 2'd3) begin
                    if (len_q == 8'd0)
                        state_d = IDLE;
                    else
                        state_d = cmd_wr_q ? WDATA : READ;
                end
            end
            WDATA: if (rx_fire && byte_cnt_q == 2'd3) state_d = WRITE;
            WRITE: if (bus_done) state_d = last_word ? IDLE : WDATA;
            READ:  if (bus_done) state_d = RDATA;
            RDATA: if (tx_fire && byte_cnt_q == 2'd3) state_d = last_word ? IDLE : READ;
            default: state_d = IDLE;
        endcase
        if (tmo_hit)
            state_d = IDLE;
    end

    always_comb begin
        outport_valid_o = (state_q == RDATA);
        mem_wr_o        = (state_q == WRITE);
    end

    assign inport_accept_o = accept_q;
    assign outport_data_o  = rdata_q[7:0];
    assign mem_req_o       = req_q;
    assign mem_addr_o      = {addr_q[31:2], 2'b00};
    assign mem_wdata_o     = wdata_q;

    // Address/data only move outside an outstanding request, so bus outputs stay stable while req is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_wr_q   <= 1'b0;
            len_q      <= 8'd0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            req_q      <= 1'b0;
            accept_q   <= 1'b0;
        end else begin
            req_q    <= (state_d == WRITE) || (state_d == READ);
            accept_q <= state_d inside {IDLE, LEN, ADDR, WDATA};
            case (state_q)
                IDLE: begin
                    byte_cnt_q <= 2'd0;
                    if (rx_fire && is_cmd)
                        cmd_wr_q <= (inport_data_i == CMD_WRITE);
                end
                LEN: if (rx_fire) len_q <= inport_data_i;
                ADDR: begin
                    if (rx_fire) begin
                        addr_q     <= {addr_q[23:0], inport_data_i};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        wdata_q    <= {inport_data_i, wdata_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                WRITE: begin
                    if (bus_done) begin
                        addr_q <= addr_q + 32'd4;
                        len_q  <= len_q - 8'd1;
                    end
                end
                READ: if (bus_done) rdata_q <= mem_rdata_i;
                RDATA: begin
                    if (tx_fire) begin
                        rdata_q    <= {8'h00, rdata_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            addr_q <= addr_q + 32'd4;
                            len_q  <= len_q - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_cmd_decoder.sv
// Self-checking bench for ftdi_cmd_decoder: byte frames in, bus transactions and tx bytes checked against a frame-level model.
module tb_ftdi_cmd_decoder;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inport_valid_i = 1'b0;
    logic [7:0]  inport_data_i = 8'h00;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [7:0]  outport_data_o;
    logic        outport_accept_i = 1'b0;
    logic        mem_req_o;
    logic        mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int stab_err = 0;
    int rx_stall = 0;
    int ack_fixed = -1;
    int acc_mode  = 0;
    int gap_max   = 0;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [7:0]  tx_obs[$];
    logic [7:0]  tx_exp[$];
    logic [31:0] plan_q[$];

    ftdi_cmd_decoder #(.TIMEOUT_W(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_accept_i (outport_accept_i),
        .mem_req_o        (mem_req_o),
        .mem_wr_o         (mem_wr_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Bus responder: acks after a fixed or random delay, read data taken from the plan queue.
    initial begin
        int  dly;
        logic busy;
        busy = 1'b0;
        dly  = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i || mem_ack_i || !mem_req_o) begin
                mem_ack_i = 1'b0;
                busy      = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    dly  = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                end
                if (dly == 0) begin
                    mem_ack_i = 1'b1;
                    if (!mem_wr_o)
                        mem_rdata_i = (plan_q.size() > 0) ? plan_q.pop_front() : $urandom;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (acc_mode)
                0:       outport_accept_i = 1'b1;
                1:       outport_accept_i = ~outport_accept_i;
                2:       outport_accept_i = 1'($urandom_range(0, 1));
                default: outport_accept_i = 1'b0;
            endcase
        end
    end

    // Observer: records completed bus transactions, tx bytes and any bus change during an open request.
    initial begin
        logic held;
        txn_t held_t;
        txn_t cur;
        held = 1'b0;
        held_t = '0;
        forever begin
            @(negedge clk_i);
            if (outport_valid_o && outport_accept_i)
                tx_obs.push_back(outport_data_o);
            cur = '{wr: mem_wr_o, addr: mem_addr_o, wdata: mem_wdata_o};
            if (mem_req_o) begin
                if (held && cur != held_t)
                    stab_err++;
                held_t = cur;
                held   = 1'b1;
                if (mem_ack_i) begin
                    obs_q.push_back(cur);
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic bq_t bytes_of(input logic [95:0] v, input int n);
        bq_t q;
        for (int i = n - 1; i >= 0; i--)
            q.push_back(v[i*8 +: 8]);
        return q;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        tx_obs.delete();
        tx_exp.delete();
        plan_q.delete();
        stab_err = 0;
        rx_stall = 0;
    endtask

    task automatic send_bytes(input bq_t b);
        int n;
        int gap;
        foreach (b[i]) begin
            inport_valid_i = 1'b1;
            inport_data_i  = b[i];
            n = 0;
            forever begin
                @(negedge clk_i);
                if (inport_accept_o) break;
                n++;
                if (n > 3000) begin
                    rx_stall++;
                    break;
                end
            end
            @(posedge clk_i);
            #1;
            inport_valid_i = 1'b0;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk_i);
                #1;
            end
        end
    endtask

    task automatic wait_for(input int ntx, input int nbytes);
        int n = 0;
        while ((obs_q.size() < ntx || tx_obs.size() < nbytes) && n < 4000) begin
            @(posedge clk_i);
            n++;
        end
        repeat (10) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] got [7];
        string       nm  [7];
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        got = '{32'(mem_req_o), 32'(mem_wr_o), mem_addr_o, mem_wdata_o,
                32'(outport_valid_o), 32'(outport_data_o), 32'(inport_accept_o)};
        nm  = '{"req", "wr", "addr", "wdata", "tx_valid", "tx_data", "rx_accept"};
        foreach (got[i]) begin
            n_checks++;
            if (got[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_%s: got %0h, required 0", nm[i], got[i]);
            end
        end
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (inport_accept_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_accept: got %b, required 1", inport_accept_o);
        end
    endtask

    task automatic test_write();
        clear_obs();
        send_bytes(bytes_of(96'h10_01_00001000_EFBEADDE, 10));
        wait_for(1, 0);
        n_checks++;
        if (obs_q.size() != 1 || rx_stall != 0) begin
            n_fail++;
            $display("FAIL write_count: got %0d txns (%0d stalls), required 1 (0)", obs_q.size(), rx_stall);
        end
        if (obs_q.size() >= 1) begin
            n_checks++;
            if (obs_q[0] !== txn_t'({1'b1, 32'h0000_1000, 32'hDEAD_BEEF})) begin
                n_fail++;
                $display("FAIL write_txn: got wr=%b addr=%h wdata=%h, required wr=1 addr=00001000 wdata=deadbeef",
                         obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata);
            end
        end
    endtask

    task automatic test_read();
        bq_t exp_b;
        clear_obs();
        plan_q.push_back(32'h1122_3344);
        plan_q.push_back(32'h5566_7788);
        send_bytes(bytes_of(96'h11_02_00002000, 6));
        wait_for(2, 8);
        n_checks++;
        if (obs_q.size() != 2 || tx_obs.size() != 8) begin
            n_fail++;
            $display("FAIL read_count: got %0d txns/%0d bytes, required 2/8", obs_q.size(), tx_obs.size());
        end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            n_checks++;
            if (obs_q[i].wr !== 1'b0 || obs_q[i].addr !== 32'h2000 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL read_txn%0d: got wr=%b addr=%h, required wr=0 addr=%h",
                         i, obs_q[i].wr, obs_q[i].addr, 32'h2000 + 32'(4 * i));
            end
        end
        exp_b = bytes_of(96'h44332211_88776655, 8);
        for (int i = 0; i < tx_obs.size() && i < 8; i++) begin
            n_checks++;
            if (tx_obs[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL read_byte%0d: got %h, required %h", i, tx_obs[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_junk_and_len0();
        clear_obs();
        send_bytes(bytes_of(96'hAA_00_10_01_00003000_0403_0201, 12));
        send_bytes(bytes_of(96'h10_00_12345678, 6));
        send_bytes(bytes_of(96'h10_01_00005004_A5B6C7D8, 10));
        wait_for(2, 0);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL junk_len0_count: got %0d txns, required 2", obs_q.size());
        end
        if (obs_q.size() >= 2) begin
            n_checks++;
            if (obs_q[0] !== txn_t'({1'b1, 32'h0000_3000, 32'h0102_0304})) begin
                n_fail++;
                $display("FAIL junk_txn: got addr=%h wdata=%h, required addr=00003000 wdata=01020304",
                         obs_q[0].addr, obs_q[0].wdata);
            end
            n_checks++;
            if (obs_q[1] !== txn_t'({1'b1, 32'h0000_5004, 32'hD8C7_B6A5})) begin
                n_fail++;
                $display("FAIL len0_next_txn: got addr=%h wdata=%h, required addr=00005004 wdata=d8c7b6a5",
                         obs_q[1].addr, obs_q[1].wdata);
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] w [2];
        int n;
        clear_obs();
        ack_fixed = 5;
        acc_mode  = 1;
        w[0] = $urandom;
        w[1] = $urandom;
        plan_q.push_back(w[0]);
        plan_q.push_back(w[1]);
        send_bytes(bytes_of(96'h11_02_FFFFFFFC, 6));
        wait_for(2, 8);
        n_checks++;
        if (obs_q.size() != 2 || tx_obs.size() != 8 || stab_err != 0) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d txns/%0d bytes/%0d unstable, required 2/8/0",
                     obs_q.size(), tx_obs.size(), stab_err);
        end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            n_checks++;
            if (obs_q[i].wr !== 1'b0 || obs_q[i].addr !== 32'hFFFF_FFFC + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got %h, required %h", i, obs_q[i].addr, 32'hFFFF_FFFC + 32'(4 * i));
            end
        end
        for (int i = 0; i < tx_obs.size() && i < 8; i++) begin
            n_checks++;
            if (tx_obs[i] !== w[i / 4][(i % 4) * 8 +: 8]) begin
                n_fail++;
                $display("FAIL wrap_byte%0d: got %h, required %h", i, tx_obs[i], w[i / 4][(i % 4) * 8 +: 8]);
            end
        end

        clear_obs();
        ack_fixed = 0;
        acc_mode  = 3;
        plan_q.push_back(32'hCAFE_F00D);
        send_bytes(bytes_of(96'h11_01_00000100, 6));
        n = 0;
        while (!outport_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (outport_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rdata_reach: got tx_valid=%b, required 1", outport_valid_o);
        end
        rst_i = 1'b1;
        #2;
        n_checks++;
        if (outport_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: got tx_valid=%b req=%b, required 0/0", outport_valid_o, mem_req_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        acc_mode  = 0;
        ack_fixed = -1;
        repeat (2) @(posedge clk_i);
        #1;
        clear_obs();
        send_bytes(bytes_of(96'h10_01_00000200_11111111, 10));
        wait_for(1, 0);
        n_checks++;
        if (obs_q.size() != 1 || tx_obs.size() != 0) begin
            n_fail++;
            $display("FAIL after_reset_count: got %0d txns/%0d bytes, required 1/0", obs_q.size(), tx_obs.size());
        end else if (obs_q[0] !== txn_t'({1'b1, 32'h0000_0200, 32'h1111_1111})) begin
            n_fail++;
            $display("FAIL after_reset_txn: got addr=%h wdata=%h, required 00000200/11111111",
                     obs_q[0].addr, obs_q[0].wdata);
        end
    endtask

    task automatic test_timeout();
        bq_t f;
        clear_obs();
        send_bytes(bytes_of(96'h10_01, 2));
        repeat (30) @(posedge clk_i);
        #1;
`ifdef FTDI_CMD_TIMEOUT_EN
        f = bytes_of(96'h10_01_00004000_A1B2C3D4, 10);
`else
        f = bytes_of(96'h00004000_A1B2C3D4, 8);
`endif
        send_bytes(f);
        wait_for(1, 0);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL gap_count: got %0d txns, required 1", obs_q.size());
        end else if (obs_q[0] !== txn_t'({1'b1, 32'h0000_4000, 32'hD4C3_B2A1})) begin
            n_fail++;
            $display("FAIL gap_txn: got addr=%h wdata=%h, required 00004000/d4c3b2a1",
                     obs_q[0].addr, obs_q[0].wdata);
        end
    endtask

    task automatic test_random();
        bq_t         s;
        logic [7:0]  j;
        logic [31:0] a, word;
        int          len;
        logic        wr;
        clear_obs();
        acc_mode = 2;
        gap_max  = 2;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                do j = 8'($urandom); while (j == 8'h10 || j == 8'h11);
                s.push_back(j);
            end
            len = $urandom_range(0, 3);
            a   = $urandom;
            wr  = 1'($urandom_range(0, 1));
            s.push_back(wr ? 8'h10 : 8'h11);
            s.push_back(8'(len));
            for (int k = 3; k >= 0; k--) s.push_back(a[k*8 +: 8]);
            for (int w = 0; w < len; w++) begin
                word = $urandom;
                if (wr) begin
                    for (int k = 0; k < 4; k++) s.push_back(word[k*8 +: 8]);
                    exp_q.push_back('{wr: 1'b1, addr: (a & 32'hFFFF_FFFC) + 32'(4 * w), wdata: word});
                end else begin
                    plan_q.push_back(word);
                    exp_q.push_back('{wr: 1'b0, addr: (a & 32'hFFFF_FFFC) + 32'(4 * w), wdata: 32'h0});
                    for (int k = 0; k < 4; k++) tx_exp.push_back(word[k*8 +: 8]);
                end
            end
        end
        send_bytes(s);
        wait_for(exp_q.size(), tx_exp.size());
        n_checks++;
        if (obs_q.size() != exp_q.size() || tx_obs.size() != tx_exp.size() || stab_err != 0 || rx_stall != 0) begin
            n_fail++;
            $display("FAIL random_count: got %0d txns/%0d bytes/%0d unstable/%0d stalls, required %0d/%0d/0/0",
                     obs_q.size(), tx_obs.size(), stab_err, rx_stall, exp_q.size(), tx_exp.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].wr && obs_q[i].wdata !== exp_q[i].wdata)) begin
                n_fail++;
                $display("FAIL random_txn%0d: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                         i, obs_q[i].wr, obs_q[i].addr, obs_q[i].wdata, exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata);
            end
        end
        for (int i = 0; i < tx_obs.size() && i < tx_exp.size(); i++) begin
            n_checks++;
            if (tx_obs[i] !== tx_exp[i]) begin
                n_fail++;
                $display("FAIL random_byte%0d: got %h, required %h", i, tx_obs[i], tx_exp[i]);
            end
        end
        acc_mode = 0;
        gap_max  = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_junk_and_len0();
        test_wrap_and_reset();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
